// File: rtl/xbar_slave_mem.sv
// xbar_slave_mem: slave-side responder for the 2x2 crossbar request/ack bus.
// Captures a single-beat read or write, waits WAIT cycles, performs the
// access on a local register-file memory and returns a one-cycle ack.
// A DONE guard cycle after ACK keeps a still-held req from double-acking.
module xbar_slave_mem #(
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned WAIT = 1,
  parameter logic        N    = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  // The wait counter is 4 bits wide; N is a one-bit informational index.
  if (WAIT > 15 || $bits(N) != 1) begin : g_param_chk
    $error("xbar_slave_mem: WAIT=%0d exceeds 15", WAIT);
  end

  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [3:0]  WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_we;
  logic [DW-1:0]   mem_q [DEPTH];

  // Next-state, capture and access-commit decode.
  // The commit uses the *_d capture values so that WAIT=0 (IDLE straight to
  // ACK) commits the request sampled on that same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cmd_d   = cmd;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT == 0) begin
            state_d = ST_ACK;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_we  = reset && (state_d == ST_ACK) && (state_q != ST_ACK) && cmd_d;
    rdata_d = rdata_q;
    if ((state_d == ST_ACK) && (state_q != ST_ACK) && !cmd_d) begin
      rdata_d = mem_q[addr_d];
    end
  end

  // Control and capture registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Register-file memory; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_d] <= wdata_d;
    end
  end

  assign ack   = (state_q == ST_ACK);
  assign busy  = (state_q != ST_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Directed bench for xbar_slave_mem: four instances with WAIT = 0..3
// (instance k has WAIT = k), each with its own inputs and reset.
module tb_xbar_slave_mem;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] req_v;
  logic [3:0] cmd_v;
  logic [3:0] addr_v  [4];
  logic [7:0] wdata_v [4];
  logic [3:0] ack_v;
  logic [3:0] busy_v;
  logic [7:0] rdata_v [4];

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    xbar_slave_mem #(
      .AW(4),
      .DW(8),
      .WAIT(g),
      .N(1'b0)
    ) u_dut (
      .clk  (clk),
      .reset(rst_v[g]),
      .req  (req_v[g]),
      .cmd  (cmd_v[g]),
      .addr (addr_v[g]),
      .wdata(wdata_v[g]),
      .ack  (ack_v[g]),
      .rdata(rdata_v[g]),
      .busy (busy_v[g])
    );
  end

  typedef struct {
    int         k;
    bit         cmd;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full transaction on instance k (WAIT = k). Cycle 0 is the capture
  // cycle; ack is expected in cycle k+1 and busy in cycles 1..k+2.
  task automatic do_txn(input int k, input bit c, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd,
                        input bit alt, input logic [3:0] a2,
                        input logic [7:0] d2, input string nm);
    int ack_cyc;
    int n_ack;
    bit busy_ok;
    ack_cyc = -1;
    n_ack   = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    req_v[k]   = 1'b1;
    cmd_v[k]   = c;
    addr_v[k]  = a;
    wdata_v[k] = d;
    for (int cy = 1; cy <= k + 3; cy++) begin
      @(negedge clk);
      if (alt && cy == 1) begin
        addr_v[k]  = a2;
        wdata_v[k] = d2;
      end
      if (busy_v[k] !== (cy <= k + 2)) busy_ok = 1'b0;
      if (ack_v[k] === 1'b1) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = cy;
        req_v[k] = 1'b0;
      end
    end
    req_v[k] = 1'b0;
    chk({nm, " ack cycle"}, ack_cyc, k + 1);
    chk({nm, " ack count"}, n_ack, 1);
    chk({nm, " busy pattern"}, {31'd0, busy_ok}, 1);
    if (!c) chk({nm, " rdata"}, {24'd0, rdata_v[k]}, {24'd0, exp_rd});
  endtask

  initial begin
    logic [8:0] mask;
    int         acks;

    tests = 0;
    fails = 0;

    tbl[0]  = '{1, 1'b1, 4'd3, 8'hA5, 8'h00};
    tbl[1]  = '{1, 1'b0, 4'd3, 8'h00, 8'hA5};
    tbl[2]  = '{0, 1'b1, 4'd1, 8'h5A, 8'h00};
    tbl[3]  = '{0, 1'b0, 4'd1, 8'h00, 8'h5A};
    tbl[4]  = '{2, 1'b1, 4'd7, 8'hE7, 8'h00};
    tbl[5]  = '{2, 1'b0, 4'd7, 8'h00, 8'hE7};
    tbl[6]  = '{3, 1'b1, 4'd2, 8'h42, 8'h00};
    tbl[7]  = '{3, 1'b1, 4'd4, 8'h99, 8'h00};
    tbl[8]  = '{3, 1'b0, 4'd2, 8'h00, 8'h42};
    tbl[9]  = '{3, 1'b0, 4'd4, 8'h00, 8'h99};
    tbl[10] = '{0, 1'b1, 4'd9, 8'hC3, 8'h00};
    tbl[11] = '{0, 1'b0, 4'd9, 8'h00, 8'hC3};

    rst_v = 4'b0000;
    req_v = 4'b0000;
    cmd_v = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      addr_v[i]  = 4'd0;
      wdata_v[i] = 8'd0;
    end

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset busy[%0d]", i), {31'd0, busy_v[i]}, 0);
      chk($sformatf("reset ack[%0d]", i), {31'd0, ack_v[i]}, 0);
      chk($sformatf("reset rdata[%0d]", i), {24'd0, rdata_v[i]}, 0);
    end
    rst_v = 4'b1111;

    // Table-driven transactions.
    for (int i = 0; i < 12; i++) begin
      do_txn(tbl[i].k, tbl[i].cmd, tbl[i].a, tbl[i].d, tbl[i].exp_rd,
             1'b0, 4'd0, 8'd0, $sformatf("vec%0d", i));
    end

    // Read data holds after the read completes.
    repeat (10) @(negedge clk);
    chk("rdata hold", {24'd0, rdata_v[1]}, 32'hA5);

    // Held req with WAIT=0: acks in cycles 1 and 4 only.
    @(negedge clk);
    req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 4'd5; wdata_v[0] = 8'h3C;
    mask = '0;
    for (int cy = 1; cy <= 5; cy++) begin
      @(negedge clk);
      if (ack_v[0] === 1'b1) mask[cy] = 1'b1;
    end
    req_v[0] = 1'b0;
    for (int cy = 6; cy <= 8; cy++) begin
      @(negedge clk);
      if (ack_v[0] === 1'b1) mask[cy] = 1'b1;
    end
    chk("held req ack mask", {23'd0, mask}, 32'h12);
    do_txn(0, 1'b0, 4'd5, 8'h00, 8'h3C, 1'b0, 4'd0, 8'd0, "held rd5");

    // Abort with WAIT=3: req drops in cycle 2.
    @(negedge clk);
    req_v[3] = 1'b1; cmd_v[3] = 1'b1; addr_v[3] = 4'd2; wdata_v[3] = 8'hFF;
    acks = 0;
    @(negedge clk);
    chk("abort busy c1", {31'd0, busy_v[3]}, 1);
    if (ack_v[3] === 1'b1) acks++;
    @(negedge clk);
    chk("abort busy c2", {31'd0, busy_v[3]}, 1);
    if (ack_v[3] === 1'b1) acks++;
    req_v[3] = 1'b0;
    @(negedge clk);
    chk("abort busy c3", {31'd0, busy_v[3]}, 0);
    if (ack_v[3] === 1'b1) acks++;
    repeat (4) begin
      @(negedge clk);
      if (ack_v[3] === 1'b1) acks++;
    end
    chk("abort ack count", acks, 0);
    do_txn(3, 1'b0, 4'd2, 8'h00, 8'h42, 1'b0, 4'd0, 8'd0, "abort rd2");

    // Reset in cycle 2 of a WAIT=3 write.
    @(negedge clk);
    req_v[3] = 1'b1; cmd_v[3] = 1'b1; addr_v[3] = 4'd4; wdata_v[3] = 8'h55;
    acks = 0;
    @(negedge clk);
    if (ack_v[3] === 1'b1) acks++;
    @(negedge clk);
    if (ack_v[3] === 1'b1) acks++;
    rst_v[3] = 1'b0;
    req_v[3] = 1'b0;
    @(negedge clk);
    chk("midrst busy", {31'd0, busy_v[3]}, 0);
    chk("midrst rdata", {24'd0, rdata_v[3]}, 0);
    if (ack_v[3] === 1'b1) acks++;
    rst_v[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack_v[3] === 1'b1) acks++;
    end
    chk("midrst ack count", acks, 0);
    do_txn(3, 1'b0, 4'd4, 8'h00, 8'h99, 1'b0, 4'd0, 8'd0, "midrst rd4");

    // Inputs change after capture with WAIT=2.
    do_txn(2, 1'b1, 4'd1, 8'h11, 8'h00, 1'b1, 4'd7, 8'h77, "chg wr");
    do_txn(2, 1'b0, 4'd1, 8'h00, 8'h11, 1'b0, 4'd0, 8'd0, "chg rd1");
    do_txn(2, 1'b0, 4'd7, 8'h00, 8'hE7, 1'b0, 4'd0, 8'd0, "chg rd7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
